// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and de-glitch the bus, frame bytes,
// fold E0/F0 prefixes into flags and queue scan events in a first-word fall-through FIFO.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_ps2_clk,
  input  logic                          i_ps2_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [7:0]                    o_code,
  output logic                          o_break,
  output logic                          o_ext,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  logic          filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  // fall is asserted for the cycle after the filtered clock drops from 1 to 0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s;
        filt_cnt <= '0;
        fall     <= filt;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] to_cnt;
  logic          rx_done;
  logic [7:0]    rx_byte;
  logic          frame_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      rx_done   <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= data_s;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if ((^{shift, par}) && data_s) begin
              rx_done <= 1'b1;
              rx_byte <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (state != IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYC)) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end
    end
  end

  logic       ext;
  logic       brk;
  logic       push;
  logic [9:0] push_data;

  // Prefix bytes only update flags; any other byte becomes an event {ext, brk, code}
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_done) begin
        if (rx_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          push      <= 1'b1;
          push_data <= {ext, brk, rx_byte};
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   level;
  logic          overflow;
  logic          full;
  logic          pop;
  logic          wr;
  logic [9:0]    head;

  assign full = (level == (AW+1)'(FIFO_DEPTH));
  assign pop  = o_valid && i_ready;
  assign wr   = push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (wr) mem[wptr] <= push_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      unique case ({wr, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  assign head = mem[rptr];

  always_comb begin
    o_valid     = (level != '0);
    o_code      = o_valid ? head[7:0] : '0;
    o_break     = o_valid ? head[8] : 1'b0;
    o_ext       = o_valid ? head[9] : 1'b0;
    o_frame_err = frame_err;
    o_overflow  = overflow;
    o_level     = level;
  end

endmodule
